// File: rtl/ram_scan_display_pkg.sv
// rtl/ram_scan_display_pkg.sv - shared state encoding and sizing helpers for ram_scan_display
package ram_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_SHOW = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int RAM_LATENCY = 1;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(32);

endpackage

// File: rtl/ram_scan_display_if.sv
// rtl/ram_scan_display_if.sv - control, RAM read port and LED signals of the scan sequencer
interface ram_scan_display_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              Start;
  logic              Pause;
  logic [ADDR_W-1:0] Base;
  logic [ADDR_W:0]   Count;
  logic [ADDR_W-1:0] Add;
  logic [DATA_W-1:0] Rd_data;
  logic [7:0]        LED;
  logic [1:0]        Byte_sel;
  logic              Busy;
  logic              Done;

  modport master (
    output Start, Pause, Base, Count, Rd_data,
    input  Add, LED, Byte_sel, Busy, Done
  );

  modport slave (
    input  Start, Pause, Base, Count, Rd_data,
    output Add, LED, Byte_sel, Busy, Done
  );
endinterface

// File: rtl/ram_scan_display_dwell_timer.sv
// rtl/ram_scan_display_dwell_timer.sv - per-byte dwell counter with terminal-count pulse
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  // Wrapping on terminal count leaves the counter ready for the next byte.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ram_scan_display.sv
// rtl/ram_scan_display.sv - reads a word range from block RAM and shows each byte on the LEDs
module ram_scan_display
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DWELL  = 50_000_000
) (
  input logic Clk,
  input logic Rst,
  ram_scan_display_if.slave bus
);
  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam logic [1:0] LAST_SEL = 2'(NBYTES - 1);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] add_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        led_q;
  logic [1:0]        byte_sel_q;
  logic              busy_q;
  logic              done_q;

  logic       tc;
  logic [1:0] next_sel_d;
  logic [7:0] next_byte_d;

  assign next_sel_d  = byte_sel_q + 2'd1;
  assign next_byte_d = word_q[8*int'(next_sel_d) +: 8];

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .clear_i (state_q == S_WAIT),
    .en_i    ((state_q == S_SHOW) && !bus.Pause),
    .tc_o    (tc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      add_q       <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      led_q       <= '0;
      byte_sel_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            if (bus.Count != '0) begin
              add_q       <= bus.Base;
              remaining_q <= bus.Count;
              busy_q      <= 1'b1;
              state_q     <= S_ADDR;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ADDR: state_q <= S_WAIT;
        S_WAIT: begin
          word_q     <= bus.Rd_data;
          led_q      <= bus.Rd_data[7:0];
          byte_sel_q <= '0;
          state_q    <= S_SHOW;
        end
        S_SHOW: begin
          if (tc) begin
            if (byte_sel_q != LAST_SEL) begin
              byte_sel_q <= next_sel_d;
              led_q      <= next_byte_d;
            end else if (remaining_q == REM_ONE) begin
              remaining_q <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              // Address wraps naturally at the top of the RAM.
              remaining_q <= remaining_q - REM_ONE;
              add_q       <= add_q + ADDR_W'(1);
              state_q     <= S_ADDR;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Add      = add_q;
  assign bus.LED      = led_q;
  assign bus.Byte_sel = byte_sel_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
endmodule

// File: tb/tb_ram_scan_display.sv
// tb/tb_ram_scan_display.sv - directed bench for ram_scan_display with a 1-cycle-latency RAM model
module tb_ram_scan_display;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ram_scan_display_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  ram_scan_display #(.ADDR_W(6), .DATA_W(32), .DWELL(2)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:63];
  always @(posedge clk) bus.Rd_data <= mem[bus.Add];

  int errors = 0;
  int checks = 0;

  logic [7:0] led_tr  [0:63];
  logic [5:0] add_tr  [0:63];
  logic [1:0] sel_tr  [0:63];
  logic       busy_tr [0:63];
  int first_done;
  int n_done;
  int hold_start = 0;
  int pulse_k = -1;
  int p_from = 0;
  int p_len = 0;

  task automatic launch(input int base, input int count);
    @(negedge clk);
    bus.Base  = 6'(base);
    bus.Count = 7'(count);
    bus.Start = 1'b1;
  endtask

  // Step n cycles after the launching edge, recording outputs at each falling edge.
  task automatic capture(input int n);
    first_done = -1;
    n_done = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      led_tr[k]  = bus.LED;
      add_tr[k]  = bus.Add;
      sel_tr[k]  = bus.Byte_sel;
      busy_tr[k] = bus.Busy;
      if (bus.Done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == 1 && hold_start == 0) bus.Start = 1'b0;
      if (k == pulse_k) begin
        bus.Start = 1'b1;
        bus.Base  = 6'd30;
      end
      if (k == pulse_k + 1) bus.Start = 1'b0;
      bus.Pause = (k >= p_from && k < p_from + p_len);
    end
    bus.Pause = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.Add !== 6'd0) begin errors++; $display("FAIL reset_add got=%0d want=0", bus.Add); end
    checks++; if (bus.LED !== 8'd0) begin errors++; $display("FAIL reset_led got=%0h want=0", bus.LED); end
    checks++; if (bus.Byte_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d want=0", bus.Byte_sel); end
    checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b want=0,0", bus.Busy, bus.Done); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_led [0:3];
    exp_led = '{8'h08, 8'h07, 8'h06, 8'h05};
    launch(5, 1);
    capture(12);
    checks++; if (add_tr[1] !== 6'd5) begin errors++; $display("FAIL single_add got=%0d want=5", add_tr[1]); end
    for (int k = 3; k <= 10; k++) begin
      checks++;
      if (led_tr[k] !== exp_led[(k-3)/2] || sel_tr[k] !== 2'((k-3)/2)) begin
        errors++;
        $display("FAIL single_led cyc=%0d got=%0h/%0d want=%0h/%0d", k, led_tr[k], sel_tr[k], exp_led[(k-3)/2], (k-3)/2);
      end
    end
    checks++; if (first_done != 11 || n_done != 1) begin errors++; $display("FAIL single_done got=%0d(x%0d) want=11(x1)", first_done, n_done); end
    checks++; if (busy_tr[10] !== 1'b1 || busy_tr[11] !== 1'b0) begin errors++; $display("FAIL single_busy got=%b%b want=10", busy_tr[10], busy_tr[11]); end
  endtask

  task automatic test_count_zero();
    launch(9, 0);
    capture(3);
    checks++; if (first_done != 1 || n_done != 1) begin errors++; $display("FAIL zero_done got=%0d(x%0d) want=1(x1)", first_done, n_done); end
    checks++; if (busy_tr[1] !== 1'b0 || busy_tr[2] !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b%b want=00", busy_tr[1], busy_tr[2]); end
    checks++; if (add_tr[2] !== 6'd5 || led_tr[2] !== 8'h05) begin errors++; $display("FAIL zero_hold add=%0d led=%0h want=5,05", add_tr[2], led_tr[2]); end
  endtask

  task automatic test_wrap();
    launch(62, 3);
    capture(32);
    checks++; if (add_tr[1] !== 6'd62 || add_tr[11] !== 6'd63 || add_tr[21] !== 6'd0) begin
      errors++; $display("FAIL wrap_add got=%0d,%0d,%0d want=62,63,0", add_tr[1], add_tr[11], add_tr[21]);
    end
    checks++; if (led_tr[3] !== 8'h41 || led_tr[13] !== 8'h42 || led_tr[23] !== 8'h03) begin
      errors++; $display("FAIL wrap_led got=%0h,%0h,%0h want=41,42,03", led_tr[3], led_tr[13], led_tr[23]);
    end
    checks++; if (first_done != 31) begin errors++; $display("FAIL wrap_done got=%0d want=31", first_done); end
  endtask

  task automatic test_pause();
    int held;
    p_from = 5;
    p_len  = 5;
    launch(0, 2);
    capture(27);
    p_len = 0;
    held = 0;
    for (int k = 1; k <= 13; k++) if (led_tr[k] === 8'h02) held++;
    checks++; if (held != 7) begin errors++; $display("FAIL pause_hold got=%0d want=7", held); end
    checks++; if (first_done != 26) begin errors++; $display("FAIL pause_done got=%0d want=26", first_done); end
  endtask

  task automatic test_abort();
    int seen_done;
    launch(10, 4);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) bus.Start = 1'b0;
    end
    checks++; if (bus.Add !== 6'd11 || bus.Busy !== 1'b1) begin errors++; $display("FAIL abort_pre add=%0d busy=%b want=11,1", bus.Add, bus.Busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.Add !== 6'd0 || bus.LED !== 8'd0 || bus.Busy !== 1'b0 || bus.Byte_sel !== 2'd0) begin
      errors++; $display("FAIL abort_state add=%0d led=%0h busy=%b sel=%0d want=0,0,0,0", bus.Add, bus.LED, bus.Busy, bus.Byte_sel);
    end
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_quiet got=%0d want=0", seen_done); end
    launch(20, 1);
    capture(12);
    checks++; if (led_tr[3] !== 8'h17 || first_done != 11) begin errors++; $display("FAIL abort_restart led=%0h done=%0d want=17,11", led_tr[3], first_done); end
  endtask

  task automatic test_back_to_back();
    int bad;
    pulse_k = 5;
    launch(1, 2);
    capture(22);
    pulse_k = -1;
    bad = 0;
    for (int k = 1; k <= 21; k++) if (add_tr[k] !== 6'd1 && add_tr[k] !== 6'd2) bad++;
    checks++; if (bad != 0 || add_tr[11] !== 6'd2) begin errors++; $display("FAIL busy_start bad=%0d add11=%0d want=0,2", bad, add_tr[11]); end
    checks++; if (first_done != 21 || n_done != 1) begin errors++; $display("FAIL busy_done got=%0d(x%0d) want=21(x1)", first_done, n_done); end
    hold_start = 1;
    launch(40, 1);
    capture(24);
    bus.Start = 1'b0;
    hold_start = 0;
    checks++; if (first_done != 11 || n_done != 2) begin errors++; $display("FAIL b2b_done got=%0d(x%0d) want=11(x2)", first_done, n_done); end
    checks++; if (busy_tr[12] !== 1'b0 || busy_tr[13] !== 1'b1 || add_tr[13] !== 6'd40) begin
      errors++; $display("FAIL b2b_rearm busy=%b%b add=%0d want=01,40", busy_tr[12], busy_tr[13], add_tr[13]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
    bus.Base  = '0;
    bus.Count = '0;
    test_reset();
    test_single_word();
    test_count_zero();
    test_wrap();
    test_pause();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
